icmp_ping_initiator: RTL and testbench

//  ICMP echo initiator: on ping_start it builds and sends one Echo Request (type 8) through the IP-layer tx handshake.
//  It then waits for the matching Echo Reply (type 0) on the IP-layer rx interface and reports round-trip time or timeout.
//  It sits beside the ICMP echo responder under the IP layer and uses the same IP tx/rx signalling.

---
 rtl/icmp_ping_initiator_if.sv | 27 ++
 rtl/icmp_ping_initiator.sv | 186 ++++++++++++++++++
 tb/tb_icmp_ping_initiator.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icmp_ping_initiator_if.sv
// IP-layer tx/rx signalling between the ICMP ping initiator and the IP layer.
// The master side is the ICMP initiator; the slave side is the IP layer.
interface icmp_ping_initiator_if;
    logic        icmp_tx_req;
    logic        ip_tx_ack;
    logic        icmp_data_req;
    logic        icmp_tx_ready;
    logic [7:0]  icmp_tx_data;
    logic        icmp_tx_end;
    logic        mac_send_end;
    logic        icmp_rx_req;
    logic [7:0]  icmp_rx_data;
    logic        icmp_rev_error;
    logic [15:0] upper_layer_data_length;

    modport master (
        output icmp_tx_req, icmp_tx_ready, icmp_tx_data, icmp_tx_end,
        input  ip_tx_ack, icmp_data_req, mac_send_end,
        input  icmp_rx_req, icmp_rx_data, icmp_rev_error, upper_layer_data_length
    );

    modport slave (
        input  icmp_tx_req, icmp_tx_ready, icmp_tx_data, icmp_tx_end,
        output ip_tx_ack, icmp_data_req, mac_send_end,
        output icmp_rx_req, icmp_rx_data, icmp_rev_error, upper_layer_data_length
    );
endinterface

// File: rtl/icmp_ping_initiator.sv
// ICMP echo initiator: builds one Echo Request per ping_start, then waits for the
// matching Echo Reply and reports round-trip time, or a timeout.
module icmp_ping_initiator #(
    parameter logic [15:0] PING_ID     = 16'h5A5A,
    parameter logic [15:0] PAYLOAD_LEN = 16'd32,
    parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000,
    parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ping_start,
    output logic                  ping_busy,
    output logic                  ping_done,
    output logic                  ping_timeout,
    output logic [31:0]           ping_rtt,
    output logic [15:0]           ping_seq,
    icmp_ping_initiator_if.master ip
);
    typedef enum logic [3:0] {
        IDLE, GEN_CSUM, REQ, WAIT_ACK, WAIT_DREQ, SEND, SEND_END,
        WAIT_RX, RX, RX_CHK, DONE, TMO
    } state_t;

    localparam logic [16:0] MSG_LEN  = {1'b0, PAYLOAD_LEN} + 17'd8;
    localparam logic [16:0] GEN_LAST = {2'b00, PAYLOAD_LEN[15:1]} + 17'd2;
    localparam logic [16:0] ACK_LAST = {1'b0, ACK_TIMEOUT} - 17'd1;
    localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

    state_t      state_reg, state_next;
    logic [16:0] cnt_reg;
    logic [31:0] timer_reg;
    logic [31:0] sum_reg;
    logic [15:0] csum_reg;
    logic [15:0] seq_reg;
    logic [31:0] rtt_reg;
    logic [15:0] rx_len_reg;
    logic [7:0]  rx_hi_reg;
    logic [15:0] rx_tc_reg, rx_id_reg, rx_seq_reg;
    logic        rx_err_reg;
    logic        mac_end_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_end_reg;

    logic [15:0] gen_word;
    logic [7:0]  tx_byte;
    logic [6:0]  pay_word;
    logic        tmo_hit, rx_last, rx_pass, counting;

    function automatic logic [15:0] fold(input logic [31:0] s);
        logic [16:0] f1;
        f1 = {1'b0, s[31:16]} + {1'b0, s[15:0]};
        return f1[15:0] + {15'd0, f1[16]};
    endfunction

    // Checksum word k and transmit byte k are both indexed by the shared state counter.
    always_comb begin
        pay_word = cnt_reg[6:0] - 7'd3;
        case (cnt_reg)
            17'd0:   gen_word = 16'h0800;
            17'd1:   gen_word = PING_ID;
            17'd2:   gen_word = seq_reg;
            default: gen_word = {pay_word, 1'b0, pay_word, 1'b1};
        endcase
        case (cnt_reg)
            17'd0:   tx_byte = 8'h08;
            17'd1:   tx_byte = 8'h00;
            17'd2:   tx_byte = csum_reg[15:8];
            17'd3:   tx_byte = csum_reg[7:0];
            17'd4:   tx_byte = PING_ID[15:8];
            17'd5:   tx_byte = PING_ID[7:0];
            17'd6:   tx_byte = seq_reg[15:8];
            17'd7:   tx_byte = seq_reg[7:0];
            default: tx_byte = cnt_reg[7:0] - 8'd8;
        endcase
    end

    assign tmo_hit  = (timer_reg >= TMO_LAST);
    assign rx_last  = ((cnt_reg + 17'd1) >= {1'b0, rx_len_reg});
    assign counting = (state_reg == SEND) || (state_reg == SEND_END) || (state_reg == WAIT_RX)
                   || (state_reg == RX) || (state_reg == RX_CHK);
    assign rx_pass  = (rx_tc_reg == 16'h0000) && (rx_id_reg == PING_ID) && (rx_seq_reg == seq_reg)
                   && (rx_len_reg == MSG_LEN[15:0]) && (fold(sum_reg) == 16'hFFFF) && !rx_err_reg;

    always_comb begin
        state_next       = state_reg;
        ping_busy        = (state_reg != IDLE);
        ping_done        = (state_reg == DONE);
        ping_timeout     = (state_reg == TMO);
        ping_rtt         = rtt_reg;
        ping_seq         = seq_reg;
        ip.icmp_tx_req   = (state_reg == REQ) || (state_reg == WAIT_ACK);
        ip.icmp_tx_ready = (state_reg == WAIT_DREQ);
        ip.icmp_tx_data  = tx_data_reg;
        ip.icmp_tx_end   = tx_end_reg;
        case (state_reg)
            IDLE:      if (ping_start) state_next = GEN_CSUM;
            GEN_CSUM:  if (cnt_reg == GEN_LAST) state_next = REQ;
            REQ:       state_next = WAIT_ACK;
            WAIT_ACK:  if (ip.ip_tx_ack) state_next = WAIT_DREQ;
            WAIT_DREQ: begin
                if (ip.icmp_data_req)          state_next = SEND;
                else if (cnt_reg == ACK_LAST)  state_next = TMO;
            end
            SEND:      if (cnt_reg == MSG_LEN) state_next = SEND_END;
            SEND_END:  if (mac_end_reg) state_next = WAIT_RX;
            WAIT_RX: begin
                if (tmo_hit)                state_next = TMO;
                else if (ip.icmp_rx_req)    state_next = RX;
            end
            RX: begin
                if (tmo_hit)       state_next = TMO;
                else if (rx_last)  state_next = RX_CHK;
            end
            // Timeout is tested first so it wins over a reply that passes in the same cycle.
            RX_CHK: begin
                if (tmo_hit)       state_next = TMO;
                else if (rx_pass)  state_next = DONE;
                else               state_next = WAIT_RX;
            end
            DONE, TMO: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            timer_reg   <= '0;
            sum_reg     <= '0;
            csum_reg    <= '0;
            seq_reg     <= '0;
            rtt_reg     <= '0;
            rx_len_reg  <= '0;
            rx_hi_reg   <= '0;
            rx_tc_reg   <= '0;
            rx_id_reg   <= '0;
            rx_seq_reg  <= '0;
            rx_err_reg  <= 1'b0;
            mac_end_reg <= 1'b0;
            tx_data_reg <= '0;
            tx_end_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= (state_next != state_reg) ? 17'd0 : cnt_reg + 17'd1;
            mac_end_reg <= ip.mac_send_end;
            if (state_reg == WAIT_DREQ) timer_reg <= '0;
            else if (counting)          timer_reg <= timer_reg + 32'd1;
            case (state_reg)
                IDLE:     sum_reg  <= '0;
                GEN_CSUM: sum_reg  <= sum_reg + {16'd0, gen_word};
                REQ:      csum_reg <= ~fold(sum_reg);
                WAIT_RX: if (ip.icmp_rx_req) begin
                    rx_len_reg <= ip.upper_layer_data_length;
                    sum_reg    <= '0;
                    rx_err_reg <= 1'b0;
                    rx_tc_reg  <= 16'hFFFF;
                end
                RX: begin
                    if (ip.icmp_rev_error) rx_err_reg <= 1'b1;
                    case (cnt_reg)
                        17'd0:   rx_tc_reg[15:8]  <= ip.icmp_rx_data;
                        17'd1:   rx_tc_reg[7:0]   <= ip.icmp_rx_data;
                        17'd4:   rx_id_reg[15:8]  <= ip.icmp_rx_data;
                        17'd5:   rx_id_reg[7:0]   <= ip.icmp_rx_data;
                        17'd6:   rx_seq_reg[15:8] <= ip.icmp_rx_data;
                        17'd7:   rx_seq_reg[7:0]  <= ip.icmp_rx_data;
                        default: ;
                    endcase
                    // A trailing odd byte is summed as the high half of a zero-padded word.
                    if (!cnt_reg[0]) begin
                        rx_hi_reg <= ip.icmp_rx_data;
                        if (rx_last) sum_reg <= sum_reg + {16'd0, ip.icmp_rx_data, 8'h00};
                    end else begin
                        sum_reg <= sum_reg + {16'd0, rx_hi_reg, ip.icmp_rx_data};
                    end
                end
                default: ;
            endcase
            tx_data_reg <= (state_reg == SEND && cnt_reg < MSG_LEN) ? tx_byte : 8'h00;
            tx_end_reg  <= (state_reg == SEND) && (cnt_reg == MSG_LEN - 17'd1);
            if (state_reg == RX_CHK && state_next == DONE) rtt_reg <= timer_reg + 32'd1;
            if (state_reg == DONE || state_reg == TMO)     seq_reg <= seq_reg + 16'd1;
        end
    end
endmodule

// File: tb/tb_icmp_ping_initiator.sv
// Bench for icmp_ping_initiator: table of reply vectors, hand-written corner sequences
// and randomized pings checked against a message-level reference model.
module tb_icmp_ping_initiator;
    localparam logic [15:0] PID  = 16'h5A5A;
    localparam int          L    = 32;
    localparam int          TMO  = 1000;
    localparam int          ACKT = 200;

    typedef logic [7:0] byte_q_t [$];

    typedef struct {
        logic [7:0]  typ;
        logic [7:0]  code;
        logic [15:0] id;
        int          seq_off;
        int          len;
        bit          bad_csum;
        int          flip;
        int          err_idx;
        bit          exp_done;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ping_start;
    logic        ping_busy, ping_done, ping_timeout;
    logic [31:0] ping_rtt;
    logic [15:0] ping_seq;

    icmp_ping_initiator_if ip();

    icmp_ping_initiator #(
        .PING_ID(PID), .PAYLOAD_LEN(16'(L)), .TIMEOUT_CYC(32'(TMO)), .ACK_TIMEOUT(16'(ACKT))
    ) dut (
        .clk(clk), .rst(rst), .ping_start(ping_start), .ping_busy(ping_busy),
        .ping_done(ping_done), .ping_timeout(ping_timeout), .ping_rtt(ping_rtt),
        .ping_seq(ping_seq), .ip(ip)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    logic [15:0] exp_seq = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
        end
    endtask

    // Internet checksum over a byte stream (big-endian words, odd tail padded).
    function automatic logic [15:0] inet_csum(input byte_q_t q);
        int unsigned s = 0;
        for (int i = 0; i < q.size(); i += 2)
            s += {q[i], (i + 1 < q.size()) ? q[i+1] : 8'h00};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic byte_q_t build_msg(input logic [7:0] typ, input logic [7:0] code,
                                          input logic [15:0] id, input logic [15:0] sq,
                                          input int len, input bit bad_csum, input int flip);
        byte_q_t q;
        logic [15:0] c;
        q = {};
        q.push_back(typ); q.push_back(code); q.push_back(8'h00); q.push_back(8'h00);
        q.push_back(id[15:8]); q.push_back(id[7:0]); q.push_back(sq[15:8]); q.push_back(sq[7:0]);
        for (int i = 0; i < len - 8; i++) q.push_back(8'(i));
        if (flip >= 0) q[flip] = q[flip] ^ 8'h5A;
        c = inet_csum(q);
        if (bad_csum) c = c ^ 16'h0001;
        q[2] = c[15:8];
        q[3] = c[7:0];
        return q;
    endfunction

    function automatic bit reply_ok(input byte_q_t q, input int len_field, input bit err,
                                    input logic [15:0] sq);
        return (q.size() == len_field) && (len_field == L + 8) && (q[0] == 8'h00) &&
               (q[1] == 8'h00) && ({q[4], q[5]} == PID) && ({q[6], q[7]} == sq) &&
               (inet_csum(q) == 16'h0000) && !err;
    endfunction

    // mode 0: normal send; mode 1: withhold data_req; mode 2: reset during SEND.
    task automatic do_ping(input int ack_dly, input int dreq_dly, input int mode,
                           output int unsigned c0);
        byte_q_t exp_q;
        int lat, n, bad, endbad, first_bad;
        exp_q = build_msg(8'h08, 8'h00, PID, exp_seq, L + 8, 1'b0, -1);
        c0 = 0;
        ping_start = 1'b1; tick(); ping_start = 1'b0;
        check("busy_on_start", 32'(ping_busy), 32'd1);
        lat = 0;
        while (!ip.icmp_tx_req && lat < 100) begin tick(); lat++; end
        check("gen_csum_cycles", lat, L / 2 + 3);
        repeat (ack_dly) tick();
        check("req_held", 32'(ip.icmp_tx_req), 32'd1);
        ip.ip_tx_ack = 1'b1; tick(); ip.ip_tx_ack = 1'b0;
        check("req_drop", 32'(ip.icmp_tx_req), 32'd0);
        check("ready_wait", 32'(ip.icmp_tx_ready), 32'd1);
        if (mode == 1) begin
            n = 0;
            while (!ping_timeout && n < ACKT + 50) begin tick(); n++; end
            check("ack_timeout_cycles", n, ACKT);
            exp_seq++;
            tick();
            check("ack_tmo_busy", 32'(ping_busy), 32'd0);
            check("ack_tmo_seq", 32'(ping_seq), 32'(exp_seq));
            $display("ping seq=%0d: data_req withheld, timeout after %0d cycles", exp_seq - 1, n);
            return;
        end
        repeat (dreq_dly) tick();
        ip.icmp_data_req = 1'b1; tick(); ip.icmp_data_req = 1'b0;
        c0 = cyc;
        bad = 0; endbad = 0; first_bad = -1;
        for (int i = 0; i < L + 8; i++) begin
            tick();
            if (mode == 2 && i == 10) begin
                rst = 1'b1; tick(); rst = 1'b0;
                check("rst_mid_outputs", 32'({ping_busy, ping_done, ping_timeout, ip.icmp_tx_req,
                      ip.icmp_tx_ready, ip.icmp_tx_end, ip.icmp_tx_data}), 32'd0);
                check("rst_mid_seq", 32'(ping_seq), 32'd0);
                check("rst_mid_rtt", ping_rtt, 32'd0);
                exp_seq = 16'd0;
                $display("ping: reset asserted during SEND at byte %0d", i);
                return;
            end
            if (ip.icmp_tx_data !== exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
            if (ip.icmp_tx_end !== (i == L + 7)) endbad++;
        end
        check("tx_bytes_bad", bad, 0);
        if (bad != 0) $display("  first differing tx byte index %0d", first_bad);
        check("tx_end_bad", endbad, 0);
        tick();
        check("tx_data_idle", 32'({ip.icmp_tx_end, ip.icmp_tx_data}), 32'd0);
        ip.mac_send_end = 1'b1; tick(); ip.mac_send_end = 1'b0;
        tick();
        $display("ping seq=%0d: request sent (%0d bytes, csum %02h%02h)", exp_seq, L + 8,
                 exp_q[2], exp_q[3]);
    endtask

    task automatic send_reply(input byte_q_t q, input int len_field, input int err_idx);
        ip.icmp_rx_req = 1'b1;
        ip.upper_layer_data_length = 16'(len_field);
        tick();
        ip.icmp_rx_req = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            ip.icmp_rx_data   = q[k];
            ip.icmp_rev_error = (k == err_idx);
            tick();
        end
        ip.icmp_rx_data   = 8'h00;
        ip.icmp_rev_error = 1'b0;
    endtask

    task automatic reply_check(input string name, input byte_q_t q, input int len_field,
                               input int err_idx, input bit exp_done, input int unsigned c0);
        bit seen;
        int unsigned at;
        logic [31:0] rtt;
        send_reply(q, len_field, err_idx);
        seen = 1'b0; at = 0; rtt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ping_done && !seen) begin seen = 1'b1; at = cyc; rtt = ping_rtt; end
        end
        check({name, "_done"}, 32'(seen), 32'(exp_done));
        if (seen) begin
            check({name, "_rtt"}, rtt, at - c0);
            exp_seq++;
            check({name, "_seq"}, 32'(ping_seq), 32'(exp_seq));
        end
        $display("reply %s: len=%0d done=%0d rtt=%0d", name, len_field, seen, rtt);
    endtask

    row_t rows[9];

    initial begin
        int unsigned c0;
        int n, kind, err;
        byte_q_t q;
        logic [7:0] typ;
        logic [15:0] id, sq;
        bit bad, expd;
        int flip;

        rows[0] = '{8'h00, 8'h00, 16'h1234, 0, L + 8, 1'b0, -1, -1, 1'b0};
        rows[1] = '{8'h00, 8'h00, PID,      0, L + 8, 1'b1, -1, -1, 1'b0};
        rows[2] = '{8'h08, 8'h00, PID,      0, L + 8, 1'b0, -1, -1, 1'b0};
        rows[3] = '{8'h00, 8'h01, PID,      0, L + 8, 1'b0, -1, -1, 1'b0};
        rows[4] = '{8'h00, 8'h00, PID,      1, L + 8, 1'b0, -1, -1, 1'b0};
        rows[5] = '{8'h00, 8'h00, PID,      0, L + 6, 1'b0, -1, -1, 1'b0};
        rows[6] = '{8'h00, 8'h00, PID,      0, L + 9, 1'b0, -1, -1, 1'b0};
        rows[7] = '{8'h00, 8'h00, PID,      0, L + 8, 1'b0, -1, 20, 1'b0};
        rows[8] = '{8'h00, 8'h00, PID,      0, L + 8, 1'b0, 15, -1, 1'b1};

        rst = 1'b1; ping_start = 1'b0;
        ip.ip_tx_ack = 1'b0; ip.icmp_data_req = 1'b0; ip.mac_send_end = 1'b0;
        ip.icmp_rx_req = 1'b0; ip.icmp_rx_data = 8'h00; ip.icmp_rev_error = 1'b0;
        ip.upper_layer_data_length = 16'd0;
        repeat (3) tick();
        check("reset_outputs", 32'({ping_busy, ping_done, ping_timeout, ip.icmp_tx_req,
              ip.icmp_tx_ready, ip.icmp_tx_end, ip.icmp_tx_data}), 32'd0);
        check("reset_seq", 32'(ping_seq), 32'd0);
        check("reset_rtt", ping_rtt, 32'd0);
        rst = 1'b0;
        tick();

        // Loop-back reply 500 cycles after SEND; a ping_start while busy must be ignored.
        do_ping(2, 3, 0, c0);
        ping_start = 1'b1; tick(); ping_start = 1'b0;
        while (cyc - c0 < 500) tick();
        reply_check("loopback", build_msg(8'h00, 8'h00, PID, exp_seq, L + 8, 1'b0, -1),
                    L + 8, -1, 1'b1, c0);
        check("loopback_busy", 32'(ping_busy), 32'd0);

        // Table of bad replies within one ping, ending with an accepted one.
        do_ping(1, 0, 0, c0);
        for (int r = 0; r < 9; r++) begin
            q = build_msg(rows[r].typ, rows[r].code, rows[r].id, exp_seq + 16'(rows[r].seq_off),
                          rows[r].len, rows[r].bad_csum, rows[r].flip);
            reply_check($sformatf("row%0d", r), q, rows[r].len, rows[r].err_idx,
                        rows[r].exp_done, c0);
        end

        // No reply: timeout exactly TMO cycles after the first SEND cycle.
        do_ping(3, 1, 0, c0);
        while (!ping_timeout && (cyc - c0) < TMO + 100) tick();
        check("rx_timeout_cycles", cyc - c0, TMO);
        exp_seq++;
        tick();
        check("rx_tmo_busy", 32'(ping_busy), 32'd0);
        check("rx_tmo_seq", 32'(ping_seq), 32'(exp_seq));
        $display("ping seq=%0d: no reply, timeout at %0d", exp_seq - 1, cyc - c0 - 1);

        // Data request withheld.
        do_ping(1, 0, 1, c0);

        // Randomized pings: one possibly corrupted reply judged by the model, then a good one.
        for (int it = 0; it < 5; it++) begin
            kind = $urandom_range(0, 6);
            do_ping($urandom_range(1, 5), $urandom_range(0, 10), 0, c0);
            repeat ($urandom_range(0, 50)) tick();
            typ = 8'h00; id = PID; sq = exp_seq; bad = 1'b0; flip = -1; err = -1;
            case (kind)
                1: flip = 8 + $urandom_range(0, L - 1);
                2: bad = 1'b1;
                3: id = PID ^ 16'($urandom_range(1, 65535));
                4: sq = exp_seq + 16'($urandom_range(1, 100));
                5: typ = 8'($urandom_range(1, 255));
                6: err = $urandom_range(0, L + 7);
                default: ;
            endcase
            q = build_msg(typ, 8'h00, id, sq, L + 8, bad, flip);
            expd = reply_ok(q, L + 8, err >= 0, exp_seq);
            reply_check($sformatf("rnd%0d_k%0d", it, kind), q, L + 8, err, expd, c0);
            if (!expd)
                reply_check($sformatf("rnd%0d_good", it),
                            build_msg(8'h00, 8'h00, PID, exp_seq, L + 8, 1'b0, -1),
                            L + 8, -1, 1'b1, c0);
        end

        // Reset during SEND, then a fresh ping must use sequence 0.
        do_ping(1, 2, 2, c0);
        tick();
        do_ping(1, 1, 0, c0);
        reply_check("after_rst", build_msg(8'h00, 8'h00, PID, exp_seq, L + 8, 1'b0, -1),
                    L + 8, -1, 1'b1, c0);

        n = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
